arcade_input_merge: RTL and testbench

- Parametrised input front-end for arcade cores. It merges PS/2 keyboard, USB joystick and DB9/DB15 UserIO joystick sources for PLAYERS players into one registered button vector per player.
- The keyboard keymap is runtime-loadable rather than hard-coded.
- Adds optional SOCD cleaning, per-button autofire and per-player coin pulse stretching.
- Sits between hps_io / joy_db* and the game core's JOY inputs.

---
 rtl/arcade_input_merge.sv | 124 ++++++++++++
 tb/tb_arcade_input_merge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_merge.sv
// Input front-end for arcade cores: merges keyboard (runtime keymap), USB and
// UserIO joysticks per player, with SOCD cleaning, autofire and coin stretch.
module arcade_input_merge #(
  parameter int PLAYERS    = 2,
  parameter int BTNS       = 8,
  parameter int COIN_BIT   = 7,
  parameter int AF_DIV     = 1500000,
  parameter int COIN_PULSE = 3000000
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic                               map_wr,
  input  logic [$clog2(PLAYERS*BTNS)-1:0]    map_idx,
  input  logic [8:0]                         map_code,
  input  logic [PLAYERS*BTNS-1:0]            joy_usb,
  input  logic [PLAYERS*BTNS-1:0]            joy_db,
  input  logic [PLAYERS-1:0]                 db_ena,
  input  logic                               socd_en,
  input  logic [PLAYERS*BTNS-1:0]            af_mask,
  output logic [PLAYERS*BTNS-1:0]            btn_out,
  output logic [PLAYERS-1:0]                 coin_out
);

  localparam int N   = PLAYERS * BTNS;
  localparam int IW  = $clog2(N);
  localparam int AFW = $clog2(AF_DIV);
  localparam int CW  = $clog2(COIN_PULSE + 1);
  localparam logic [AFW-1:0] AF_LAST   = AFW'(AF_DIV - 1);
  localparam logic [CW-1:0]  COIN_LOAD = CW'(COIN_PULSE);

  logic [8:0]     r_map [N];
  logic [N-1:0]   r_key;
  logic           r_old_toggle;
  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;
  logic [N-1:0]   r_btn;
  logic [CW-1:0]  r_coin_cnt [PLAYERS];
  logic [PLAYERS-1:0] r_coin_prev;

  logic           w_evt;
  logic [N-1:0]   w_btn;

  assign w_evt   = (ps2_key[10] != r_old_toggle);
  assign btn_out = r_btn;

  // Keymap and key state. The map write is placed after the event update so
  // that its clear overrides a simultaneous event on the same entry, while the
  // event still compares against the pre-write table contents.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) r_map[i] <= '0;
      r_key        <= '0;
      r_old_toggle <= ps2_key[10];
    end else begin
      r_old_toggle <= ps2_key[10];
      for (int unsigned i = 0; i < N; i++) begin
        if (w_evt && (r_map[i] != '0) && (r_map[i] == ps2_key[8:0]))
          r_key[i] <= ps2_key[9];
        if (map_wr && (map_idx == IW'(i))) begin
          r_map[i] <= map_code;
          r_key[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (r_af_cnt == AF_LAST) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + AFW'(1);
    end
  end

  always_comb begin
    w_btn = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      w_btn[p*BTNS +: BTNS] = r_key[p*BTNS +: BTNS] |
                              (db_ena[p] ? joy_db[p*BTNS +: BTNS] : joy_usb[p*BTNS +: BTNS]);
      if (socd_en && w_btn[p*BTNS + 3] && w_btn[p*BTNS + 2]) begin
        w_btn[p*BTNS + 3] = 1'b0;
        w_btn[p*BTNS + 2] = 1'b0;
      end
      if (socd_en && w_btn[p*BTNS + 1] && w_btn[p*BTNS + 0]) begin
        w_btn[p*BTNS + 1] = 1'b0;
        w_btn[p*BTNS + 0] = 1'b0;
      end
    end
    w_btn = w_btn & ~(af_mask & {N{~r_af_phase}});
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_btn <= '0;
    else       r_btn <= w_btn;
  end

  // Coin stretch: a rising edge only loads an idle counter, so pulses during
  // an active stretch never extend it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int unsigned p = 0; p < PLAYERS; p++) r_coin_cnt[p] <= '0;
      r_coin_prev <= '0;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        r_coin_prev[p] <= r_btn[p*BTNS + COIN_BIT];
        if (r_coin_cnt[p] != '0)
          r_coin_cnt[p] <= r_coin_cnt[p] - CW'(1);
        else if (r_btn[p*BTNS + COIN_BIT] && !r_coin_prev[p])
          r_coin_cnt[p] <= COIN_LOAD;
      end
    end
  end

  always_comb begin
    coin_out = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) coin_out[p] = (r_coin_cnt[p] != '0);
  end

endmodule

// File: tb/tb_arcade_input_merge.sv
// Directed bench for arcade_input_merge: vector table for the merge/SOCD path
// plus hand-written sequences for keymap, autofire, coin stretch and reset.
module tb_arcade_input_merge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        map_wr;
  logic [3:0]  map_idx;
  logic [8:0]  map_code;
  logic [15:0] joy_usb;
  logic [15:0] joy_db;
  logic [1:0]  db_ena;
  logic        socd_en;
  logic [15:0] af_mask;
  logic [15:0] btn_out;
  logic [1:0]  coin_out;

  logic        tog;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [1:0]  db;
    logic [15:0] usb;
    logic [15:0] jdb;
    logic        socd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  arcade_input_merge #(
    .PLAYERS    (2),
    .BTNS       (8),
    .COIN_BIT   (7),
    .AF_DIV     (4),
    .COIN_PULSE (10)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .map_wr   (map_wr),
    .map_idx  (map_idx),
    .map_code (map_code),
    .joy_usb  (joy_usb),
    .joy_db   (joy_db),
    .db_ena   (db_ena),
    .socd_en  (socd_en),
    .af_mask  (af_mask),
    .btn_out  (btn_out),
    .coin_out (coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic map(input int idx, input logic [8:0] code);
    map_wr   = 1'b1;
    map_idx  = 4'(idx);
    map_code = code;
    step();
    map_wr   = 1'b0;
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s [24];
    int   t;
    logic found;
    logic pulse, e;

    vecs[0]  = '{2'b01, 16'h0808, 16'h0008, 1'b0, 16'h0808};
    vecs[1]  = '{2'b01, 16'h0808, 16'h0000, 1'b0, 16'h0800};
    vecs[2]  = '{2'b00, 16'h000C, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{2'b00, 16'h000C, 16'h0000, 1'b0, 16'h000C};
    vecs[4]  = '{2'b00, 16'h0003, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{2'b00, 16'h0003, 16'h0000, 1'b0, 16'h0003};
    vecs[6]  = '{2'b00, 16'h0F0F, 16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{2'b00, 16'h0A35, 16'h0000, 1'b1, 16'h0A35};
    vecs[8]  = '{2'b00, 16'h0E07, 16'h0000, 1'b1, 16'h0204};
    vecs[9]  = '{2'b10, 16'h0070, 16'h3300, 1'b0, 16'h3370};
    vecs[10] = '{2'b11, 16'h6F6F, 16'h1040, 1'b0, 16'h1040};
    vecs[11] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    tog = 1'b0; ps2_key = '0; map_wr = 1'b0; map_idx = '0; map_code = '0;
    joy_usb = '0; joy_db = '0; db_ena = '0; socd_en = 1'b0; af_mask = '0;
    reset = 1'b1;
    step(); step(); step();
    chk("reset_btn", btn_out, 16'h0000);
    chk("reset_coin", coin_out, 2'b00);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      db_ena  = vecs[i].db;
      joy_usb = vecs[i].usb;
      joy_db  = vecs[i].jdb;
      socd_en = vecs[i].socd;
      step();
      chk($sformatf("vec%0d", i), btn_out, vecs[i].exp);
    end
    socd_en = 1'b0; db_ena = '0;

    // Autofire: AF_DIV=4 gives 4 cycles on, 4 cycles off.
    af_mask = 16'h0010;
    joy_usb = 16'h0010;
    step();
    for (int i = 0; i < 24; i++) begin
      step();
      s[i] = btn_out[4];
    end
    found = 1'b0;
    t = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && (s[i] != s[i-1])) begin
        found = 1'b1;
        t = i;
      end
    end
    chk("af_edge_found", 32'(found), 32'd1);
    if (found) begin
      for (int k = 1; k < 12; k++)
        chk($sformatf("af_pattern_k%0d", k), 32'(s[t+k]), 32'(s[t] ^ ((k / 4) % 2 == 1)));
    end
    af_mask = '0;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("af_off_steady", btn_out, 16'h0010);
    end
    joy_usb = '0;
    step();

    // Coin stretch on P1: pulses at steps 0, 5 (ignored) and 12 (retrigger).
    for (int j = 0; j < 25; j++) begin
      pulse = (j == 0) || (j == 5) || (j == 12);
      e     = ((j >= 1) && (j <= 10)) || ((j >= 13) && (j <= 22));
      joy_usb = pulse ? 16'h8000 : 16'h0000;
      step();
      chk($sformatf("coin_out_s%0d", j), coin_out, {e, 1'b0});
      chk($sformatf("coin_btn_s%0d", j), btn_out, {pulse, 15'h0000});
    end
    joy_usb = '0;
    step();

    // Keyboard path.
    map(5, 9'h029);
    key(1'b1, 9'h029);
    step(); chk("key_lat1", btn_out, 16'h0000);
    step(); chk("key_press", btn_out, 16'h0020);
    key(1'b1, 9'h075);
    step(); step(); chk("unmapped", btn_out, 16'h0020);
    key(1'b0, 9'h029);
    step(); chk("rel_lat1", btn_out, 16'h0020);
    step(); chk("key_release", btn_out, 16'h0000);

    key(1'b1, 9'h029);
    map_wr = 1'b1; map_idx = 4'd6; map_code = 9'h029;
    step(); map_wr = 1'b0;
    step(); chk("evt_old_table", btn_out, 16'h0020);
    key(1'b0, 9'h029);
    step(); step(); chk("rel_after_map", btn_out, 16'h0000);
    key(1'b1, 9'h029);
    step(); step(); chk("multi_map", btn_out, 16'h0060);
    key(1'b0, 9'h029);
    step(); step(); chk("multi_rel", btn_out, 16'h0000);

    key(1'b1, 9'h029);
    map_wr = 1'b1; map_idx = 4'd5; map_code = 9'h029;
    step(); map_wr = 1'b0;
    step(); chk("clear_wins", btn_out, 16'h0040);
    key(1'b0, 9'h029);
    step(); step(); chk("clear_rel", btn_out, 16'h0000);

    map(0, 9'h01B);
    key(1'b1, 9'h01B);
    step(); step(); chk("held_key0", btn_out, 16'h0001);
    map(0, 9'h01B);
    chk("remap_lat1", btn_out, 16'h0001);
    step(); chk("remap_drop", btn_out, 16'h0000);
    key(1'b0, 9'h01B);
    step(); step();

    // Reset in the middle of a held key and an active coin stretch.
    map(1, 9'h01C);
    key(1'b1, 9'h01C);
    step(); step(); chk("held_key1", btn_out, 16'h0002);
    joy_usb = 16'h8000;
    step(); joy_usb = '0;
    chk("coin_btn_pre_rst", btn_out, 16'h8002);
    step(); chk("coin_pre_rst", coin_out, 2'b10);
    reset = 1'b1;
    step();
    chk("rst_mid_btn", btn_out, 16'h0000);
    chk("rst_mid_coin", coin_out, 2'b00);
    reset = 1'b0;
    step();
    chk("post_rst_btn", btn_out, 16'h0000);
    chk("post_rst_coin", coin_out, 2'b00);
    key(1'b1, 9'h01C);
    step(); step(); chk("old_map_dead", btn_out, 16'h0000);
    key(1'b1, 9'h029);
    step(); step(); chk("old_map5_dead", btn_out, 16'h0000);
    chk("post_rst_coin2", coin_out, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
